// File: rtl/sumador_serie_ctrl.sv
// Byte-serial W-bit add/subtract sequencer: one 8-bit adder is reused over
// NBYTES clocks, LSB byte first, with the carry held in a register.

module adder8B (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       entAcarreo,
  output logic [7:0] suma,
  output logic       salAcarreo
);
  assign {salAcarreo, suma} = {1'b0, a} + {1'b0, b} + {8'd0, entAcarreo};
endmodule

module sumador_serie_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inicio,
  input  logic                resta,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                entAcarreo,
  output logic                ocupado,
  output logic                listo,
  output logic [8*NBYTES-1:0] resultado,
  output logic                salAcarreo,
  output logic                desbordamiento
);
  localparam int W  = 8*NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] ULTIMO = IW'(NBYTES-1);

  typedef enum logic {REPOSO, SUMA} estado_t;

  estado_t       estado, estadoSig;
  logic [W-1:0]  opA, opB;
  logic [W-9:0]  sombra;
  logic [IW-1:0] idx;
  logic          acarreo;
  logic          restaReg;
  logic [7:0]    byteSuma;
  logic          byteAcarreo;
  logic [W-1:0]  cadena;

  // Operands shift right one byte per cycle, so the adder always sees bits [7:0].
  adder8B uSumador (
    .a          (opA[7:0]),
    .b          (opB[7:0]),
    .entAcarreo (acarreo),
    .suma       (byteSuma),
    .salAcarreo (byteAcarreo)
  );

  assign cadena = {byteSuma, sombra};

  always_ff @(posedge clk) begin
    if (rst) estado <= REPOSO;
    else     estado <= estadoSig;
  end

  always_comb begin
    estadoSig = estado;
    case (estado)
      REPOSO:  if (inicio) estadoSig = SUMA;
      SUMA:    if (idx == ULTIMO) estadoSig = REPOSO;
      default: estadoSig = REPOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado == SUMA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opA            <= '0;
      opB            <= '0;
      sombra         <= '0;
      idx            <= '0;
      acarreo        <= 1'b0;
      restaReg       <= 1'b0;
      listo          <= 1'b0;
      resultado      <= '0;
      salAcarreo     <= 1'b0;
      desbordamiento <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (estado)
        REPOSO: if (inicio) begin
          opA      <= a;
          opB      <= resta ? ~b : b;
          acarreo  <= resta ? 1'b1 : entAcarreo;
          restaReg <= resta;
          idx      <= '0;
        end
        SUMA: begin
          opA     <= opA >> 8;
          opB     <= opB >> 8;
          sombra  <= cadena[W-1:8];
          acarreo <= byteAcarreo;
          idx     <= idx + 1'b1;
          if (idx == ULTIMO) begin
            // Only the MSB byte remains in opA/opB here, so bit 7 is the sign.
            resultado      <= cadena;
            salAcarreo     <= byteAcarreo;
            desbordamiento <= (opA[7] == opB[7]) & (byteSuma[7] != opA[7]);
            listo          <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// Randomized scoreboard bench for sumador_serie_ctrl with an arithmetic reference model.

module tb_sumador_serie_ctrl;
  localparam int NBYTES = 4;
  localparam int W      = 8*NBYTES;

  logic         clk, rst, inicio, resta, entAcarreo;
  logic [W-1:0] a, b;
  logic         ocupado, listo, salAcarreo, desbordamiento;
  logic [W-1:0] resultado;

  sumador_serie_ctrl #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .resta(resta), .a(a), .b(b),
    .entAcarreo(entAcarreo), .ocupado(ocupado), .listo(listo),
    .resultado(resultado), .salAcarreo(salAcarreo), .desbordamiento(desbordamiento)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   lastAcc = -100;
  int   passCnt = 0;
  int   totalCnt = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ir, input logic ic);
    exp_t e;
    longint ua, ub, sa, sb, sv, full;
    ua = longint'({1'b0, ia});
    ub = longint'({1'b0, ib});
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    if (ir) begin
      full = ua - ub;
      e.co = (ua >= ub);
      sv   = sa - sb;
    end else begin
      full = ua + ub + longint'(ic);
      e.co = (full >= (longint'(1) <<< W));
      sv   = sa + sb + longint'(ic);
    end
    e.res = full[W-1:0];
    e.ov  = (sv > ((longint'(1) <<< (W-1)) - 1)) || (sv < -(longint'(1) <<< (W-1)));
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: compare on every listo pulse, and ocupado on every cycle.
  always @(negedge clk) begin
    exp_t e;
    chk("ocupado", {63'd0, ocupado}, {63'd0, (cyc >= lastAcc) && (cyc <= lastAcc + 3)});
    if (listo) begin
      if (sbq.size() == 0) chk("spurious listo", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("listo cycle", 64'(cyc), 64'(e.cyc));
        chk("resultado", {32'd0, resultado}, {32'd0, e.res});
        chk("salAcarreo", {63'd0, salAcarreo}, {63'd0, e.co});
        chk("desbordamiento", {63'd0, desbordamiento}, {63'd0, e.ov});
      end
    end
  end

  // Issue one request; during the busy cycles the inputs are scrambled to show they are ignored.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ir, input logic ic, input bit hold);
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; resta = ir; entAcarreo = ic; inicio = 1'b1;
    @(posedge clk); #1;
    e = model(ia, ib, ir, ic);
    e.cyc = cyc + 4;
    sbq.push_back(e);
    lastAcc = cyc;
    repeat (4) begin
      @(negedge clk);
      inicio = hold ? 1'b1 : 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom);
      resta = 1'($urandom_range(0, 1)); entAcarreo = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      inicio = 1'b0;
    end
  endtask

  task automatic chkZero(input string name);
    chk({name, " resultado"}, {32'd0, resultado}, 64'd0);
    chk({name, " salAcarreo"}, {63'd0, salAcarreo}, 64'd0);
    chk({name, " desb"}, {63'd0, desbordamiento}, 64'd0);
    chk({name, " listo"}, {63'd0, listo}, 64'd0);
  endtask

  initial begin
    rst = 1; inicio = 1; resta = 0; entAcarreo = 0; a = '0; b = '0;
    // Reset held with inicio asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkZero("reset");
    rst = 0; inicio = 0;

    // Directed arithmetic cases
    issue(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    idle(2);
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    issue(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b0);
    issue(32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b0);
    issue(32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b0);
    issue(32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0);
    idle(1);

    // inicio held through a busy operation, back-to-back acceptance
    issue(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    issue(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Reset in the second SUMA cycle aborts the operation
    begin
      @(negedge clk);
      a = 32'h11111111; b = 32'h22222222; resta = 0; entAcarreo = 0; inicio = 1;
      @(posedge clk); #1;
      lastAcc = cyc;
      @(negedge clk); inicio = 0;
      @(negedge clk); rst = 1;
      @(posedge clk); #1;
      lastAcc = -100;
      sbq.delete();
      @(negedge clk);
      chkZero("abort");
      rst = 0;
    end
    issue(32'h00000010, 32'h00000020, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Randomized operations with random gaps
    for (int i = 0; i < 60; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    issue(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0);
    issue(32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);

    idle(1);
    for (int t = 0; t < 20 && sbq.size() > 0; t++) @(negedge clk);
    chk("drain", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
